// File: rtl/csa_resolver.sv
// Digit-serial resolver: turns a carry-save pair (vs, vc) into a binary sum
// modulo 2^WIDTH, adding DIGIT bits per clock behind valid/ready handshakes.
module csa_resolver #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vs,
  input  logic [WIDTH-1:0] in_vc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW    = DIGIT + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   vs_q;
  logic [WIDTH-1:0]   vc_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [DIGIT-1:0]   vs_dig_c;
  logic [DIGIT-1:0]   vc_dig_c;
  logic [DW-1:0]      dadd_c;
  logic               last_c;

  // Select the operand digits addressed by the slice counter.
  always_comb begin
    vs_dig_c = '0;
    vc_dig_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        vs_dig_c = vs_q[k*DIGIT +: DIGIT];
        vc_dig_c = vc_q[k*DIGIT +: DIGIT];
      end
    end
  end

  assign dadd_c = DW'(vs_dig_c) + DW'(vc_dig_c) + DW'(carry_q);
  assign last_c = (cnt_q == CNT_W'(N - 1));

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vs_q      <= '0;
      vc_q      <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            vs_q     <= in_vs;
            vc_q     <= in_vc;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              out_sum[k*DIGIT +: DIGIT] <= dadd_c[DIGIT-1:0];
            end
          end
          carry_q <= dadd_c[DIGIT];
          if (last_c) begin
            out_cout  <= dadd_c[DIGIT];
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // No same-cycle accept: in_ready only returns after the drain.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
Digit-serial carry-propagate resolver. It converts a carry-save pair (VS, VC) from the SHA-256 compression datapath into a binary sum modulo 2^WIDTH. It sits after the CSA tree and before the working-variable registers. It trades area for latency by adding DIGIT bits per clock, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand and result width in bits
DIGIT, 8, bits resolved per clock; must divide WIDTH; N = WIDTH/DIGIT

Ports:
clk        input   1      clock, all state updates on rising edge
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      carry-save pair on in_vs/in_vc is valid
in_ready   output  1      block can accept a pair
in_vs      input   WIDTH  partial-sum vector
in_vc      input   WIDTH  carry vector, already weight-aligned (bit0 normally 0; any value accepted)
out_valid  output  1      out_sum/out_cout valid
out_ready  input   1      downstream accepts result
out_sum    output  WIDTH  (in_vs + in_vc) mod 2^WIDTH
out_cout   output  1      carry out of bit WIDTH-1

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0. State=IDLE, digit counter=0, carry=0.
- Reset asserted mid-operation: the operation is aborted with no output. All state returns to reset values immediately, independent of clk.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid&in_ready on an edge, register in_vs and in_vc, clear carry and the counter, and go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, slice k = bits [k*DIGIT +: DIGIT]. The DIGIT-bit add vs_k + vc_k + carry writes slice k of the result register, the carry register takes the digit carry-out, and k increments. After slice N-1 is written, out_cout takes the final carry and the FSM goes to DONE.
  - DONE: out_valid=1. out_sum and out_cout are held stable until out_ready=1. On an edge with out_valid&out_ready, go to IDLE and out_valid falls. in_ready stays 0 in DONE; there is no same-cycle accept.
- Latency: accept edge at cycle t. The RUN edges are t+1..t+N, and out_valid is high in the cycle after edge t+N. Default config: 4 RUN cycles.
- Throughput: one result per N+2 cycles at best (accept, N RUN cycles, drain).
- Inputs are sampled only at the accept edge. Later changes on in_vs/in_vc have no effect.
- in_valid while in_ready=0 is ignored. The source must hold it per the valid/ready rule.
- out_sum changes only in RUN. Slices of the previous result are overwritten progressively, but out_valid=0 during that time.
- DIGIT=WIDTH is legal: a single RUN cycle.
- Arithmetic is unsigned modulo 2^WIDTH. out_cout is informational; SHA-256 ignores it.

Test Plan:
1. in_vs=0xFFFFFFFF, in_vc=0x00000002, out_ready=1 -> out_sum=0x00000001, out_cout=1; out_valid is high exactly 5 cycles after the accept edge (carry ripples through all 4 digits).
2. in_vs=0x12345678, in_vc=0x11111110 -> out_sum=0x23456788, out_cout=0.
3. Backpressure: hold out_ready=0 for 3 cycles after out_valid, and drive in_valid=1 with a new pair throughout. Required: out_sum is held stable; in_ready=0; the new pair is not accepted until the cycle after the out handshake.
4. Reset mid-RUN: pulse rst_n=0 after 2 RUN cycles, asynchronously between edges. Required: out_valid=0, out_sum=0, and in_ready=1 immediately; the next pair resolves correctly.
5. Random back-to-back stream of 1000 pairs generated by a CSA model from random X/Y/Z. Required: out_sum == X+Y+Z mod 2^32, with no lost or duplicated results under random out_ready.
6. DIGIT=32 build with vectors from case 1 -> same results, with out_valid 2 cycles after the accept edge.
